// File: rtl/combination_lock_param_fsm.sv
// N-digit combination lock with edge-detected keys, failure lockout, relock and code reprogramming.
// Outputs decode registered state only; the stored code is replaced atomically after a full program pass.
module combination_lock_param_fsm #(
  parameter int                          N_DIGITS       = 4,
  parameter int                          DIGIT_W        = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE   = 16'h597D,
  parameter logic [N_DIGITS-1:0]         KEY_SEQ        = 4'b1010,
  parameter int                          MAX_FAIL       = 3,
  parameter int                          LOCKOUT_CYCLES = 16,
  parameter int                          OPEN_W         = 4,
  localparam int                         IDX_W          = $clog2(N_DIGITS)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Key1,
  input  logic               Key2,
  input  logic [DIGIT_W-1:0] Password,
  input  logic               Relock,
  input  logic               SetCode,
  output logic [1:0]         state,
  output logic [OPEN_W-1:0]  Open,
  output logic               Lockout,
  output logic               Programming,
  output logic [IDX_W-1:0]   digit_idx,
  output logic [3:0]         fail_cnt
);

  localparam int                 TMR_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [3:0]         MAX_F    = 4'(MAX_FAIL);

  // Handshake: there is none; Key1/Key2 are levels and a digit is taken only on the
  // cycle a key rises, with the result visible after the following posedge.
  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_OPEN    = 2'd1,
    S_PROG    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [3:0]         fail_q, fail_n, fail_inc;
  logic [TMR_W-1:0]   timer_q, timer_n;
  logic [DIGIT_W-1:0] code_q  [N_DIGITS];
  logic [DIGIT_W-1:0] code_n  [N_DIGITS];
  logic [DIGIT_W-1:0] stage_q [N_DIGITS];
  logic [DIGIT_W-1:0] stage_n [N_DIGITS];
  logic               key1_q, key2_q;
  logic               p1, p2, e, both;

  assign p1       = Key1 & ~key1_q;
  assign p2       = Key2 & ~key2_q;
  assign e        = KEY_SEQ[idx_q] ? p2 : p1;
  assign both     = p1 & p2;
  assign fail_inc = (fail_q == MAX_F) ? fail_q : fail_q + 4'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_ENTRY;
      idx_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      key1_q  <= 1'b0;
      key2_q  <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        code_q[i]  <= DEFAULT_CODE[i*DIGIT_W +: DIGIT_W];
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      fail_q  <= fail_n;
      timer_q <= timer_n;
      key1_q  <= Key1;
      key2_q  <= Key2;
      code_q  <= code_n;
      stage_q <= stage_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    fail_n  = fail_q;
    timer_n = timer_q;
    code_n  = code_q;
    stage_n = stage_q;
    case (state_q)
      S_ENTRY: begin
        if (both || (e && (Password != code_q[idx_q]))) begin
          idx_n  = '0;
          fail_n = fail_inc;
          if (fail_inc == MAX_F) begin
            state_n = S_LOCKOUT;
            timer_n = TMR_LOAD;
          end
        end else if (e) begin
          if (idx_q == LAST_IDX) begin
            state_n = S_OPEN;
            idx_n   = '0;
            fail_n  = '0;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      S_OPEN: begin
        if (Relock) begin
          state_n = S_ENTRY;
          idx_n   = '0;
        end else if (SetCode) begin
          state_n = S_PROG;
          idx_n   = '0;
        end
      end
      S_PROG: begin
        // Aborts leave code_q untouched; only a completed pass commits the staging copy.
        if (Relock) begin
          state_n = S_ENTRY;
          idx_n   = '0;
        end else if (both) begin
          state_n = S_OPEN;
          idx_n   = '0;
        end else if (e) begin
          stage_n[idx_q] = Password;
          if (idx_q == LAST_IDX) begin
            code_n  = stage_n;
            state_n = S_ENTRY;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_n = S_ENTRY;
          fail_n  = '0;
          idx_n   = '0;
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end
      default: state_n = S_ENTRY;
    endcase
  end

  assign state       = state_q;
  assign Open        = {OPEN_W{state_q == S_OPEN}};
  assign Lockout     = (state_q == S_LOCKOUT);
  assign Programming = (state_q == S_PROG);
  assign digit_idx   = idx_q;
  assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_combination_lock_param_fsm.sv
// Bench for combination_lock_param_fsm: directed scenarios plus random traffic, each cycle
// compared against a cycle-level behavioural model of the lock rules.
module tb_combination_lock_param_fsm;

  localparam int N        = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_LEN = 16;
  localparam logic [N-1:0] KEYS = 4'b1010;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Key1 = 1'b0, Key2 = 1'b0, Relock = 1'b0, SetCode = 1'b0;
  logic [3:0] Password = '0;
  logic [1:0] state;
  logic [3:0] Open;
  logic       Lockout, Programming;
  logic [1:0] digit_idx;
  logic [3:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  // model: 0=ENTRY 1=OPEN 2=PROG 3=LOCKOUT
  int m_state, m_idx, m_fail, m_lock_left;
  int m_code [N];
  int m_stage[N];
  bit pk1, pk2;

  combination_lock_param_fsm dut (
    .Clk(Clk), .Reset(Reset), .Key1(Key1), .Key2(Key2), .Password(Password),
    .Relock(Relock), .SetCode(SetCode), .state(state), .Open(Open), .Lockout(Lockout),
    .Programming(Programming), .digit_idx(digit_idx), .fail_cnt(fail_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_fail = 0; m_lock_left = 0;
    m_code = '{13, 7, 9, 5};
    pk1 = 0; pk2 = 0;
  endtask

  task automatic model_update(input bit k1, k2, input int pw, input bit rl, sc, rst);
    bit p1, p2, e, both;
    if (rst) begin
      model_reset();
      return;
    end
    p1 = k1 && !pk1;
    p2 = k2 && !pk2;
    pk1 = k1; pk2 = k2;
    e = KEYS[m_idx] ? p2 : p1;
    both = p1 && p2;
    case (m_state)
      0: begin
        if (both || (e && pw != m_code[m_idx])) begin
          m_idx = 0;
          m_fail = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
          if (m_fail == MAX_FAIL) begin m_state = 3; m_lock_left = LOCK_LEN; end
        end else if (e) begin
          m_idx++;
          if (m_idx == N) begin m_state = 1; m_idx = 0; m_fail = 0; end
        end
      end
      1: begin
        if (rl) begin m_state = 0; m_idx = 0; end
        else if (sc) begin m_state = 2; m_idx = 0; end
      end
      2: begin
        if (rl) begin m_state = 0; m_idx = 0; end
        else if (both) begin m_state = 1; m_idx = 0; end
        else if (e) begin
          m_stage[m_idx] = pw;
          m_idx++;
          if (m_idx == N) begin m_code = m_stage; m_state = 0; m_idx = 0; end
        end
      end
      default: begin
        m_lock_left--;
        if (m_lock_left == 0) begin m_state = 0; m_fail = 0; m_idx = 0; end
      end
    endcase
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".state"}, int'(state), m_state);
    check({ctx, ".open"}, int'(Open), (m_state == 1) ? 15 : 0);
    check({ctx, ".lockout"}, int'(Lockout), (m_state == 3) ? 1 : 0);
    check({ctx, ".prog"}, int'(Programming), (m_state == 2) ? 1 : 0);
    check({ctx, ".idx"}, int'(digit_idx), m_idx);
    check({ctx, ".fail"}, int'(fail_cnt), m_fail);
  endtask

  task automatic step(input string ctx, input bit k1, k2, input int pw, input bit rl, sc, rst);
    @(negedge Clk);
    Key1 = k1; Key2 = k2; Password = 4'(pw); Relock = rl; SetCode = sc; Reset = rst;
    @(posedge Clk);
    model_update(k1, k2, pw, rl, sc, rst);
    #1;
    check_all(ctx);
  endtask

  // press the key assigned to the current digit slot (or a given key), then release
  task automatic press(input string ctx, input bit use_k2, input int pw);
    step(ctx, !use_k2, use_k2, pw, 0, 0, 0);
    step(ctx, 0, 0, pw, 0, 0, 0);
  endtask

  task automatic enter(input string ctx, input int d0, d1, d2, d3);
    press(ctx, 0, d0); press(ctx, 1, d1); press(ctx, 0, d2); press(ctx, 1, d3);
  endtask

  initial begin
    int lk;
    bool_t_dummy: begin end
    model_reset();
    step("reset", 0, 0, 0, 0, 0, 1);
    step("reset", 0, 0, 0, 0, 0, 1);
    step("idle", 0, 0, 0, 0, 0, 0);

    // correct default code opens
    enter("open_default", 13, 7, 9, 5);
    check("open_value", int'(Open), 15);
    step("relock", 0, 0, 0, 1, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0);

    // wrong key ignored, wrong digit fails
    press("t2_d0", 0, 13);
    press("t2_wrongkey", 0, 7);
    check("t2_idx_after_k1", int'(digit_idx), 1);
    press("t2_wrongdigit", 1, 8);
    check("t2_fail", int'(fail_cnt), 1);

    // two more failures -> lockout of fixed length, keys ignored meanwhile
    press("t3_wrong2", 0, 1);
    step("t3_wrong3", 1, 1, 0, 0, 0, 0);
    lk = (Lockout === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && !(state === 2'd0 && lk > 0); i++) begin
      int dig;
      dig = (i / 2 == 0) ? 13 : (i / 2 == 1) ? 7 : (i / 2 == 2) ? 9 : 5;
      if (i < 8 && i % 2 == 0) step("t3_lock", KEYS[i/2] == 0, KEYS[i/2] == 1, dig, 1, 1, 0);
      else step("t3_lock", 0, 0, 0, 0, 0, 0);
      if (Lockout === 1'b1) lk++;
    end
    check("t3_lockout_len", lk, LOCK_LEN);
    check("t3_after_state", int'(state), 0);
    check("t3_after_fail", int'(fail_cnt), 0);

    // held key counts once
    for (int i = 0; i < 10; i++) step("t4_hold", 1, 0, 13, 0, 0, 0);
    check("t4_idx", int'(digit_idx), 1);
    step("t4_rel", 0, 0, 0, 0, 0, 0);
    press("t4_d1", 1, 7); press("t4_d2", 0, 9); press("t4_d3", 1, 5);
    check("t4_open", int'(state), 1);

    // reprogram to 1,2,3,4
    step("t5_set", 0, 0, 0, 0, 1, 0);
    step("t5_setrel", 0, 0, 0, 0, 0, 0);
    enter("t5_prog", 1, 2, 3, 4);
    check("t5_state", int'(state), 0);
    enter("t5_old", 13, 7, 9, 5);
    check("t5_old_closed", int'(state), 0);
    enter("t5_new", 1, 2, 3, 4);
    check("t5_new_open", int'(state), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit k1, k2, rl, sc, rst;
      int pw;
      rst = ($urandom_range(0, 99) == 0);
      k1 = ($urandom_range(0, 2) == 0);
      k2 = ($urandom_range(0, 2) == 0);
      rl = ($urandom_range(0, 19) == 0);
      sc = ($urandom_range(0, 7) == 0);
      if (m_state == 0 && $urandom_range(0, 3) != 0) pw = m_code[m_idx];
      else pw = $urandom_range(0, 15);
      step("rand", k1, k2, pw, rl, sc, rst);
    end

    // reset mid-entry and mid-programming restores default code
    step("t6_reset", 0, 0, 0, 0, 0, 1);
    press("t6_d0", 0, 13); press("t6_d1", 1, 7);
    check("t6_idx2", int'(digit_idx), 2);
    step("t6_reset_mid", 0, 0, 0, 0, 0, 1);
    check("t6_idx0", int'(digit_idx), 0);
    enter("t6_open", 13, 7, 9, 5);
    step("t6_set", 0, 0, 0, 0, 1, 0);
    step("t6_setrel", 0, 0, 0, 0, 0, 0);
    press("t6_p0", 0, 2); press("t6_p1", 1, 2);
    check("t6_prog", int'(Programming), 1);
    step("t6_reset_prog", 0, 0, 0, 0, 0, 1);
    check("t6_state0", int'(state), 0);
    enter("t6_default", 13, 7, 9, 5);
    check("t6_default_open", int'(state), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
